// File: rtl/recip_issue_ctrl.sv
// Issue controller between a tagged operand stream and a single, non-pipelined reciprocal unit.
// One request is outstanding at a time; tagged results wait in a first-word-fall-through FIFO.
module recip_issue_ctrl #(
  parameter int DATA_WIDTH     = 24,
  parameter int TAG_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [TAG_WIDTH-1:0]  s_tag,
  input  logic                  inv_ready,
  output logic [DATA_WIDTH-1:0] inv_a,
  output logic                  inv_a_dv,
  input  logic [DATA_WIDTH-1:0] inv_result,
  input  logic                  inv_result_dv,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  m_err,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  err;
  } entry_t;

  state_t               state;
  state_t               state_nxt;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 accept;
  logic                 zero_op;
  logic                 timed_out;
  logic                 push;
  logic                 pop;
  entry_t               push_entry;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 fifo_full;
  logic                 fifo_empty;
  entry_t               head;

  // Issuing only with a free FIFO slot is what guarantees a later push never meets a full FIFO.
  assign s_ready   = rstn & (state == IDLE) & inv_ready & ~fifo_full;
  assign accept    = s_valid & s_ready;
  assign zero_op   = (s_data == '0);
  assign timed_out = (tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !zero_op) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (inv_result_dv)  state_nxt = IDLE;
               else if (timed_out) state_nxt = RECOVER;
      RECOVER: if (inv_ready)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe on the last WAIT cycle wins over the timeout.
  always_comb begin
    push            = 1'b0;
    push_entry.data = '0;
    push_entry.tag  = tag_q;
    push_entry.err  = 1'b0;
    case (state)
      IDLE: if (accept && zero_op) begin
        push            = 1'b1;
        push_entry.data = '1;
        push_entry.tag  = s_tag;
        push_entry.err  = 1'b1;
      end
      WAIT: if (inv_result_dv) begin
        push            = 1'b1;
        push_entry.data = inv_result;
      end else if (timed_out) begin
        push            = 1'b1;
        push_entry.err  = 1'b1;
      end
      default: ;
    endcase
  end

  // inv_a_dv is registered: the unit's inv_ready is combinational on it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inv_a    <= '0;
      inv_a_dv <= 1'b0;
      tag_q    <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (accept && !zero_op) begin
          inv_a    <= s_data;
          inv_a_dv <= 1'b1;
          tag_q    <= s_tag;
        end
        ISSUE: begin
          inv_a_dv <= 1'b0;
          tmo_cnt  <= '0;
        end
        WAIT: if (!inv_result_dv && !timed_out) tmo_cnt <= tmo_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = ~fifo_empty & m_ready;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag gates the outputs, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head    = mem[rd_ptr];
  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_empty ? '0 : head.data;
  assign m_tag   = fifo_empty ? '0 : head.tag;
  assign m_err   = ~fifo_empty & head.err;
  assign busy    = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_recip_issue_ctrl.sv
// Bench for recip_issue_ctrl: a behavioural reciprocal-unit stub (result = ~operand after L cycles)
// plus directed timing scenarios and a randomized stream checked against an operand/result queue model.
module tb_recip_issue_ctrl;
  localparam int DW  = 24;
  localparam int TW  = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [TW-1:0] s_tag = '0;
  logic          inv_ready;
  logic [DW-1:0] inv_a;
  logic          inv_a_dv;
  logic [DW-1:0] inv_result;
  logic          inv_result_dv;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  logic          m_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  recip_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .inv_ready(inv_ready), .inv_a(inv_a), .inv_a_dv(inv_a_dv), .inv_result(inv_result),
    .inv_result_dv(inv_result_dv), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tag(m_tag), .m_err(m_err), .busy(busy)
  );

  // Reciprocal-unit stub: samples the strobe, answers ~A as a one-cycle pulse L cycles later.
  bit            stub_busy = 1'b0;
  bit            stub_dv   = 1'b0;
  int            stub_cnt  = 0;
  int            stub_lat  = 7;
  logic [DW-1:0] stub_op   = '0;
  logic [DW-1:0] stub_res  = '0;

  assign inv_ready     = !stub_busy && !inv_a_dv;
  assign inv_result    = stub_res;
  assign inv_result_dv = stub_dv;

  always begin
    @(negedge clk);
    #1;
    if (!rstn) begin
      stub_busy = 1'b0;
      stub_dv   = 1'b0;
      stub_cnt  = 0;
    end else if (stub_dv) begin
      stub_dv   = 1'b0;
      stub_busy = 1'b0;
    end else if (stub_busy) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_dv  = 1'b1;
        stub_res = ~stub_op;
      end
    end else if (inv_a_dv === 1'b1) begin
      stub_busy = 1'b1;
      stub_cnt  = stub_lat + 1;
      stub_op   = inv_a;
    end
  end

  typedef struct {logic [DW-1:0] data; logic [TW-1:0] tag;} op_t;
  typedef struct {logic [DW-1:0] data; logic [TW-1:0] tag; logic err;} res_t;

  op_t  op_q[$];
  res_t exp_q[$];

  function automatic res_t model(input op_t op);
    res_t r;
    r.tag  = op.tag;
    r.err  = (op.data == '0);
    r.data = (op.data == '0) ? {DW{1'b1}} : ~op.data;
    return r;
  endfunction

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  // Drives queued ops and pops results; mode 0: m_ready low, 1: m_ready high, 2: everything random.
  task automatic run_stream(input int mode, input int budget, input bit drain);
    bit            pv = 1'b0;
    bit            pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [TW-1:0] pt = '0;
    logic          pe = 1'b0;
    bit            done = 1'b0;
    res_t          e;
    for (int c = 0; c < budget && !done; c++) begin
      tick;
      if (pv && !pr) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== pd || m_tag !== pt || m_err !== pe) begin
          bad++;
          $display("FAIL stall_hold: got v=%b %h/%h/%b want v=1 %h/%h/%b", m_valid, m_data, m_tag, m_err, pd, pt, pe);
        end
      end
      if (op_q.size() == 0) s_valid = 1'b0;
      else if (mode != 2 || s_valid || $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1;
        s_data  = op_q[0].data;
        s_tag   = op_q[0].tag;
      end else s_valid = 1'b0;
      m_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 2) stub_lat = $urandom_range(0, 12);
      if (s_valid && s_ready) exp_q.push_back(model(op_q.pop_front()));
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got %h/%h/%b want nothing", m_data, m_tag, m_err);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.data || m_tag !== e.tag || m_err !== e.err) begin
            bad++;
            $display("FAIL result: got %h/%h/%b want %h/%h/%b", m_data, m_tag, m_err, e.data, e.tag, e.err);
          end
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pt = m_tag; pe = m_err;
      if (drain && op_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    tick;
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (drain) begin
      total++;
      if (!done) begin
        bad++;
        $display("FAIL drain_timeout: got pending=%0d want 0", op_q.size() + exp_q.size());
      end
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_tag !== '0 || m_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b %h/%h/%b busy=%b want all 0", m_valid, m_data, m_tag, m_err, busy);
    end
    total++;
    if (inv_a !== '0 || inv_a_dv !== 1'b0) begin
      bad++; $display("FAIL reset_inv: got a=%h dv=%b want 0/0", inv_a, inv_a_dv);
    end
    rstn = 1'b1;
    tick;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single_op;
    int            dv_cnt = 0;
    int            mv_at  = -1;
    logic [DW-1:0] a_seen = '0;
    stub_lat = 7;
    tick;
    s_valid = 1'b1; s_data = 24'h000010; s_tag = 4'd3;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", s_ready); end
    for (int k = 1; k <= 16; k++) begin
      tick;
      if (k == 1) s_valid = 1'b0;
      if (inv_a_dv === 1'b1) begin dv_cnt++; a_seen = inv_a; end
      if (m_valid === 1'b1 && mv_at < 0) mv_at = k;
    end
    total++; if (dv_cnt != 1) begin bad++; $display("FAIL single_dv_len: got %0d want 1", dv_cnt); end
    total++; if (a_seen !== 24'h000010) begin bad++; $display("FAIL single_inv_a: got %h want 000010", a_seen); end
    total++; if (mv_at != 10) begin bad++; $display("FAIL single_latency: got %0d want 10", mv_at); end
    total++;
    if (m_data !== 24'hFFFFEF || m_tag !== 4'd3 || m_err !== 1'b0) begin
      bad++; $display("FAIL single_result: got %h/%h/%b want ffffef/3/0", m_data, m_tag, m_err);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_pop: got v=%b busy=%b want 0/0", m_valid, busy);
    end
  endtask

  task automatic test_zero;
    tick;
    s_valid = 1'b1; s_data = '0; s_tag = 4'd5;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL zero_ready: got %b want 1", s_ready); end
    tick;
    s_valid = 1'b0;
    total++;
    if (m_valid !== 1'b1 || m_data !== 24'hFFFFFF || m_tag !== 4'd5 || m_err !== 1'b1) begin
      bad++; $display("FAIL zero_result: got v=%b %h/%h/%b want 1 ffffff/5/1", m_valid, m_data, m_tag, m_err);
    end
    total++;
    if (inv_a_dv !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL zero_no_issue: got dv=%b ready=%b want 0/1", inv_a_dv, s_ready);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    total++; if (inv_a_dv !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL zero_after: got dv=%b v=%b want 0/0", inv_a_dv, m_valid);
    end
  endtask

  task automatic test_back_to_back;
    op_t o;
    stub_lat = 3;
    for (int i = 0; i < 6; i++) begin
      o.data = DW'(24'h000100 + i * 24'h000111);
      o.tag  = TW'(i);
      op_q.push_back(o);
    end
    run_stream(0, 60, 1'b0);
    total++;
    if (exp_q.size() != 4 || op_q.size() != 2) begin
      bad++; $display("FAIL b2b_accepted: got %0d/%0d want 4/2", exp_q.size(), op_q.size());
    end
    total++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_tag !== 4'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_full: got ready=%b v=%b tag=%h busy=%b want 0/1/0/1", s_ready, m_valid, m_tag, busy);
    end
    run_stream(1, 200, 1'b1);
  endtask

  task automatic test_timeout;
    int mv_at = -1;
    int sr_at = -1;
    stub_lat = 75;
    tick;
    s_valid = 1'b1; s_data = 24'h000123; s_tag = 4'd9;
    for (int k = 1; k <= 90; k++) begin
      tick;
      if (k == 1) s_valid = 1'b0;
      if (m_valid === 1'b1 && mv_at < 0) mv_at = k;
      if (s_ready === 1'b1 && sr_at < 0) sr_at = k;
    end
    total++; if (mv_at != TMO + 2) begin bad++; $display("FAIL timeout_at: got %0d want %0d", mv_at, TMO + 2); end
    total++;
    if (m_data !== '0 || m_tag !== 4'd9 || m_err !== 1'b1) begin
      bad++; $display("FAIL timeout_entry: got %h/%h/%b want 000000/9/1", m_data, m_tag, m_err);
    end
    total++; if (sr_at != 79) begin bad++; $display("FAIL recover_exit: got %0d want 79", sr_at); end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL late_strobe_dropped: got v=%b want 0", m_valid); end
  endtask

  task automatic test_final_strobe;
    int mv_at = -1;
    stub_lat = TMO - 1;
    tick;
    s_valid = 1'b1; s_data = 24'h0F0F0F; s_tag = 4'hA;
    for (int k = 1; k <= 70; k++) begin
      tick;
      if (k == 1) s_valid = 1'b0;
      if (m_valid === 1'b1 && mv_at < 0) mv_at = k;
    end
    total++; if (mv_at != TMO + 2) begin bad++; $display("FAIL final_strobe_at: got %0d want %0d", mv_at, TMO + 2); end
    total++;
    if (m_data !== 24'hF0F0F0 || m_tag !== 4'hA || m_err !== 1'b0) begin
      bad++; $display("FAIL final_strobe_result: got %h/%h/%b want f0f0f0/a/0", m_data, m_tag, m_err);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    total++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL final_strobe_extra: got v=%b busy=%b want 0/0", m_valid, busy);
    end
  endtask

  task automatic test_reset_in_wait;
    op_t o;
    stub_lat = 20;
    tick;
    s_valid = 1'b1; s_data = 24'h000777; s_tag = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) s_valid = 1'b0;
    end
    rstn = 1'b0;
    tick;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_wait_ready: got %b want 0", s_ready); end
    total++;
    if (inv_a !== '0 || inv_a_dv !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_tag !== '0 || m_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_wait_outputs: got a=%h dv=%b v=%b %h/%h/%b busy=%b want all 0",
                      inv_a, inv_a_dv, m_valid, m_data, m_tag, m_err, busy);
    end
    rstn = 1'b1;
    for (int k = 0; k < 25; k++) tick;
    total++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL rst_wait_quiet: got v=%b busy=%b ready=%b want 0/0/1", m_valid, busy, s_ready);
    end
    o.data = 24'h012345; o.tag = 4'd7;
    op_q.push_back(o);
    run_stream(1, 40, 1'b1);
  endtask

  task automatic test_random;
    op_t o;
    for (int i = 0; i < 60; i++) begin
      o.data = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, (1 << DW) - 1));
      o.tag  = TW'($urandom_range(0, (1 << TW) - 1));
      op_q.push_back(o);
    end
    run_stream(2, 6000, 1'b1);
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL random_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_single_op;
    test_zero;
    test_back_to_back;
    test_timeout;
    test_final_strobe;
    test_reset_in_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
